// File: rtl/uart_tx_frame_gen.sv
// rtl/uart_tx_frame_gen.sv - UART Tx framer: start, data LSB-first, optional parity, stop; UART_TX_STOP2_EN adds a second stop bit
module uart_tx_frame_gen #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  Data_Valid,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
`ifdef UART_TX_STOP2_EN
    input  logic                  STOP2,
`endif
    output logic                  TX_OUT,
    output logic                  Busy
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
`ifdef UART_TX_STOP2_EN
        , STOP_2
`endif
    } state_t;

    state_t                state;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] data_lat;
    logic                  par_en_lat;
    logic                  par_typ_lat;
    logic                  parity_bit;
`ifdef UART_TX_STOP2_EN
    logic                  stop2_lat;
`endif

    assign parity_bit = (^data_lat) ^ par_typ_lat;

    // Outputs are registered from the current state, so each bit appears one edge after its state is entered.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            data_lat    <= '0;
            par_en_lat  <= 1'b0;
            par_typ_lat <= 1'b0;
`ifdef UART_TX_STOP2_EN
            stop2_lat   <= 1'b0;
`endif
            TX_OUT      <= 1'b1;
            Busy        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                    if (Data_Valid) begin
                        data_lat    <= P_DATA;
                        par_en_lat  <= PAR_EN;
                        par_typ_lat <= PAR_TYP;
`ifdef UART_TX_STOP2_EN
                        stop2_lat   <= STOP2;
`endif
                        state       <= START;
                    end
                end
                START: begin
                    TX_OUT  <= 1'b0;
                    Busy    <= 1'b1;
                    bit_cnt <= '0;
                    state   <= DATA;
                end
                DATA: begin
                    TX_OUT <= data_lat[bit_cnt];
                    Busy   <= 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state <= par_en_lat ? PARITY : STOP;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    TX_OUT <= parity_bit;
                    Busy   <= 1'b1;
                    state  <= STOP;
                end
                STOP: begin
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b1;
`ifdef UART_TX_STOP2_EN
                    state  <= stop2_lat ? STOP_2 : IDLE;
`else
                    state  <= IDLE;
`endif
                end
`ifdef UART_TX_STOP2_EN
                STOP_2: begin
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b1;
                    state  <= IDLE;
                end
`endif
                default: begin
                    TX_OUT <= 1'b1;
                    Busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
